point_update_scheduler: RTL and testbench

Sequences the single shared point-update engine (position/velocity integration plus obstacle collision) across every node of the squishy car body, once per physics frame. Holds the node state array and issues one engine job per node in index order, writing each result back. Sits between the frame timer and the update engine; the renderer reads node state through a registered read port.

---
 rtl/point_update_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_point_update_scheduler.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : point_update_scheduler
//  Description : Walks the shared point-update engine over every node of the
//                car body once per physics frame. Owns the node state array,
//                issues one engine job per node in index order, commits each
//                result and exposes node state on a registered read port.
//  Revision    : 1.0  initial release
// ============================================================================
module point_update_scheduler #(
    parameter int NUM_NODES      = 8,
    parameter int POSITION_SIZE  = 8,
    parameter int VELOCITY_SIZE  = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,

    // frame control
    input  logic                     frame_start_in,

    // initial state load (honoured only while idle)
    input  logic                     init_valid_in,
    input  logic [IDX_W-1:0]         init_idx_in,
    input  logic [POSITION_SIZE-1:0] init_pos_x_in,
    input  logic [POSITION_SIZE-1:0] init_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0] init_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0] init_vel_y_in,

    // engine request side
    output logic                     eng_begin_out,
    output logic [POSITION_SIZE-1:0] eng_pos_x_out,
    output logic [POSITION_SIZE-1:0] eng_pos_y_out,
    output logic [VELOCITY_SIZE-1:0] eng_vel_x_out,
    output logic [VELOCITY_SIZE-1:0] eng_vel_y_out,

    // engine result side
    input  logic                     eng_result_in,
    input  logic [POSITION_SIZE-1:0] eng_new_pos_x_in,
    input  logic [POSITION_SIZE-1:0] eng_new_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0] eng_new_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0] eng_new_vel_y_in,

    // renderer read port
    input  logic [IDX_W-1:0]         rd_idx_in,
    output logic [POSITION_SIZE-1:0] rd_pos_x_out,
    output logic [POSITION_SIZE-1:0] rd_pos_y_out,
    output logic [VELOCITY_SIZE-1:0] rd_vel_x_out,
    output logic [VELOCITY_SIZE-1:0] rd_vel_y_out,

    // status
    output logic                     busy_out,
    output logic                     frame_done_out,
    output logic [15:0]              frame_count_out,
    output logic                     overrun_out,
    output logic                     timeout_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The wait counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int               c_TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    // Last WAIT cycle index: leaving here gives exactly TIMEOUT_CYCLES waits.
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_NODES - 1);
    // Node count one bit wider than an index, for range checks on
    // externally supplied indices when NUM_NODES is not a power of two.
    localparam logic [IDX_W:0]     c_NODES_EXT = (IDX_W + 1)'(NUM_NODES);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // Node state array; fields are two's complement and stored bit-exact.
    logic [POSITION_SIZE-1:0] r_node_px [NUM_NODES];
    logic [POSITION_SIZE-1:0] r_node_py [NUM_NODES];
    logic [VELOCITY_SIZE-1:0] r_node_vx [NUM_NODES];
    logic [VELOCITY_SIZE-1:0] r_node_vy [NUM_NODES];

    logic [IDX_W-1:0]         r_idx;
    logic [c_TMO_W-1:0]       r_tmo_cnt;

    logic [POSITION_SIZE-1:0] r_eng_px;
    logic [POSITION_SIZE-1:0] r_eng_py;
    logic [VELOCITY_SIZE-1:0] r_eng_vx;
    logic [VELOCITY_SIZE-1:0] r_eng_vy;

    logic [POSITION_SIZE-1:0] r_rd_px;
    logic [POSITION_SIZE-1:0] r_rd_py;
    logic [VELOCITY_SIZE-1:0] r_rd_vx;
    logic [VELOCITY_SIZE-1:0] r_rd_vy;

    logic [15:0]              r_frame_cnt;
    logic                     r_overrun;
    logic                     r_timeout;

    // ------------------------------------------------------------------------
    // Control strobes from the next-state logic
    // ------------------------------------------------------------------------
    logic                     w_init_in_range;
    logic                     w_rd_in_range;
    logic                     w_init_wr;
    logic                     w_load_eng;
    logic                     w_capture;
    logic                     w_timeout;
    logic                     w_overrun;
    logic [IDX_W-1:0]         w_idx_next;

    // Engine operand source; an init write to the node about to be issued
    // in the same cycle is forwarded so the engine sees the new value.
    logic                     w_bypass;
    logic [POSITION_SIZE-1:0] w_src_px;
    logic [POSITION_SIZE-1:0] w_src_py;
    logic [VELOCITY_SIZE-1:0] w_src_vx;
    logic [VELOCITY_SIZE-1:0] w_src_vy;

    assign w_init_in_range = ({1'b0, init_idx_in} < c_NODES_EXT);
    assign w_rd_in_range   = ({1'b0, rd_idx_in}   < c_NODES_EXT);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_init_wr    = 1'b0;
        w_load_eng   = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_idx_next   = r_idx;
        w_overrun    = frame_start_in && (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                w_init_wr = init_valid_in && w_init_in_range;
                if (frame_start_in) begin
                    w_state_next = S_ISSUE;
                    w_idx_next   = '0;
                    w_load_eng   = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_result_in) begin
                    w_capture    = 1'b1;
                    w_state_next = S_WRITE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ISSUE;
                    w_idx_next   = r_idx + 1'b1;
                    w_load_eng   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand select for the next engine job, with init-write forwarding.
    always_comb begin
        w_bypass = w_init_wr && (init_idx_in == w_idx_next);
        if (w_bypass) begin
            w_src_px = init_pos_x_in;
            w_src_py = init_pos_y_in;
            w_src_vx = init_vel_x_in;
            w_src_vy = init_vel_y_in;
        end else begin
            w_src_px = r_node_px[w_idx_next];
            w_src_py = r_node_py[w_idx_next];
            w_src_vx = r_node_vx[w_idx_next];
            w_src_vy = r_node_vy[w_idx_next];
        end
    end

    // Node index register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_idx <= '0;
        end else begin
            r_idx <= w_idx_next;
        end
    end

    // Engine wait counter: cleared on issue, counts every WAIT cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Node array: idle-time init writes and engine result commits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                r_node_px[i] <= '0;
                r_node_py[i] <= '0;
                r_node_vx[i] <= '0;
                r_node_vy[i] <= '0;
            end
        end else begin
            if (w_init_wr) begin
                r_node_px[init_idx_in] <= init_pos_x_in;
                r_node_py[init_idx_in] <= init_pos_y_in;
                r_node_vx[init_idx_in] <= init_vel_x_in;
                r_node_vy[init_idx_in] <= init_vel_y_in;
            end
            if (w_capture) begin
                r_node_px[r_idx] <= eng_new_pos_x_in;
                r_node_py[r_idx] <= eng_new_pos_y_in;
                r_node_vx[r_idx] <= eng_new_vel_x_in;
                r_node_vy[r_idx] <= eng_new_vel_y_in;
            end
        end
    end

    // Engine operand registers, loaded on entry to ISSUE and held through WAIT.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_eng_px <= '0;
            r_eng_py <= '0;
            r_eng_vx <= '0;
            r_eng_vy <= '0;
        end else if (w_load_eng) begin
            r_eng_px <= w_src_px;
            r_eng_py <= w_src_py;
            r_eng_vx <= w_src_vx;
            r_eng_vy <= w_src_vy;
        end
    end

    // Registered renderer read port; out-of-range indices read as zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_px <= '0;
            r_rd_py <= '0;
            r_rd_vx <= '0;
            r_rd_vy <= '0;
        end else if (w_rd_in_range) begin
            r_rd_px <= r_node_px[rd_idx_in];
            r_rd_py <= r_node_py[rd_idx_in];
            r_rd_vx <= r_node_vx[rd_idx_in];
            r_rd_vy <= r_node_vy[rd_idx_in];
        end else begin
            r_rd_px <= '0;
            r_rd_py <= '0;
            r_rd_vx <= '0;
            r_rd_vy <= '0;
        end
    end

    // Frame counter and sticky error flags (cleared only by reset).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_overrun) begin
                r_overrun <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // ------------------------------------------------------------------------
    assign eng_begin_out   = (r_state == S_ISSUE);
    assign busy_out        = (r_state != S_IDLE);
    assign frame_done_out  = (r_state == S_DONE);
    assign eng_pos_x_out   = r_eng_px;
    assign eng_pos_y_out   = r_eng_py;
    assign eng_vel_x_out   = r_eng_vx;
    assign eng_vel_y_out   = r_eng_vy;
    assign rd_pos_x_out    = r_rd_px;
    assign rd_pos_y_out    = r_rd_py;
    assign rd_vel_x_out    = r_rd_vx;
    assign rd_vel_y_out    = r_rd_vy;
    assign frame_count_out = r_frame_cnt;
    assign overrun_out     = r_overrun;
    assign timeout_out     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_point_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_point_update_scheduler
//  Description : Self-checking bench for point_update_scheduler with a model
//                engine (latency 4, returns pos+vel) and an issue scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_point_update_scheduler;

    localparam int NN          = 8;
    localparam int PW          = 8;
    localparam int VW          = 8;
    localparam int IW          = 3;
    localparam int TMO         = 20;
    localparam int ENG_L       = 4;
    localparam int FRAME_BOUND = NN * (TMO + 2) + 50;

    logic           clk_in         = 1'b0;
    logic           rst_in         = 1'b1;
    logic           frame_start_in = 1'b0;
    logic           init_valid_in  = 1'b0;
    logic [IW-1:0]  init_idx_in    = '0;
    logic [PW-1:0]  init_pos_x_in  = '0;
    logic [PW-1:0]  init_pos_y_in  = '0;
    logic [VW-1:0]  init_vel_x_in  = '0;
    logic [VW-1:0]  init_vel_y_in  = '0;
    logic           eng_result_in  = 1'b0;
    logic [PW-1:0]  eng_new_pos_x_in = '0;
    logic [PW-1:0]  eng_new_pos_y_in = '0;
    logic [VW-1:0]  eng_new_vel_x_in = '0;
    logic [VW-1:0]  eng_new_vel_y_in = '0;
    logic [IW-1:0]  rd_idx_in      = '0;

    logic           eng_begin_out;
    logic [PW-1:0]  eng_pos_x_out, eng_pos_y_out;
    logic [VW-1:0]  eng_vel_x_out, eng_vel_y_out;
    logic [PW-1:0]  rd_pos_x_out, rd_pos_y_out;
    logic [VW-1:0]  rd_vel_x_out, rd_vel_y_out;
    logic           busy_out, frame_done_out, overrun_out, timeout_out;
    logic [15:0]    frame_count_out;

    point_update_scheduler #(
        .NUM_NODES      (NN),
        .POSITION_SIZE  (PW),
        .VELOCITY_SIZE  (VW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .frame_start_in   (frame_start_in),
        .init_valid_in    (init_valid_in),
        .init_idx_in      (init_idx_in),
        .init_pos_x_in    (init_pos_x_in),
        .init_pos_y_in    (init_pos_y_in),
        .init_vel_x_in    (init_vel_x_in),
        .init_vel_y_in    (init_vel_y_in),
        .eng_begin_out    (eng_begin_out),
        .eng_pos_x_out    (eng_pos_x_out),
        .eng_pos_y_out    (eng_pos_y_out),
        .eng_vel_x_out    (eng_vel_x_out),
        .eng_vel_y_out    (eng_vel_y_out),
        .eng_result_in    (eng_result_in),
        .eng_new_pos_x_in (eng_new_pos_x_in),
        .eng_new_pos_y_in (eng_new_pos_y_in),
        .eng_new_vel_x_in (eng_new_vel_x_in),
        .eng_new_vel_y_in (eng_new_vel_y_in),
        .rd_idx_in        (rd_idx_in),
        .rd_pos_x_out     (rd_pos_x_out),
        .rd_pos_y_out     (rd_pos_y_out),
        .rd_vel_x_out     (rd_vel_x_out),
        .rd_vel_y_out     (rd_vel_y_out),
        .busy_out         (busy_out),
        .frame_done_out   (frame_done_out),
        .frame_count_out  (frame_count_out),
        .overrun_out      (overrun_out),
        .timeout_out      (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [7:0] px;
        logic [7:0] py;
        logic [7:0] vx;
        logic [7:0] vy;
    } rec_t;

    rec_t       sb[$];
    logic [7:0] m_px [NN];
    logic [7:0] m_py [NN];
    logic [7:0] m_vx [NN];
    logic [7:0] m_vy [NN];

    int n_tests    = 0;
    int n_fail     = 0;
    int exp_frames = 0;

    // model engine state
    int         eng_total    = 0;
    int         eng_cnt      = 0;
    int         withhold_abs = -1;
    int         spur_req     = 0;
    int         spur_ack     = 0;
    bit         spur_issue   = 1'b0;
    logic [7:0] p_px, p_py, p_vx, p_vy;

    // Model engine: result pulse lands in the (ENG_L+1)-th WAIT cycle.
    always @(negedge clk_in) begin
        eng_result_in = 1'b0;
        if (rst_in) begin
            eng_cnt = 0;
        end else if (spur_req != spur_ack) begin
            spur_ack = spur_req;
            eng_result_in = 1'b1;
            eng_new_pos_x_in = 8'h55; eng_new_pos_y_in = 8'h55;
            eng_new_vel_x_in = 8'h55; eng_new_vel_y_in = 8'h55;
        end else if (eng_begin_out) begin
            eng_total++;
            p_px = eng_pos_x_out + eng_vel_x_out;
            p_py = eng_pos_y_out + eng_vel_y_out;
            p_vx = eng_vel_x_out;
            p_vy = eng_vel_y_out;
            eng_cnt = (eng_total == withhold_abs) ? 0 : ENG_L + 1;
            if (spur_issue) begin
                eng_result_in = 1'b1;
                eng_new_pos_x_in = 8'h55; eng_new_pos_y_in = 8'h55;
                eng_new_vel_x_in = 8'h55; eng_new_vel_y_in = 8'h55;
            end
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_result_in = 1'b1;
                eng_new_pos_x_in = p_px; eng_new_pos_y_in = p_py;
                eng_new_vel_x_in = p_vx; eng_new_vel_y_in = p_vy;
            end
        end
    end

    task automatic init_node(input int idx, input logic [7:0] px, input logic [7:0] py,
                             input logic [7:0] vx, input logic [7:0] vy);
        @(negedge clk_in);
        init_valid_in = 1'b1;
        init_idx_in   = idx[IW-1:0];
        init_pos_x_in = px; init_pos_y_in = py;
        init_vel_x_in = vx; init_vel_y_in = vy;
        @(negedge clk_in);
        init_valid_in = 1'b0;
    endtask

    task automatic read_node(input int idx, output logic [7:0] px, output logic [7:0] py,
                             output logic [7:0] vx, output logic [7:0] vy);
        @(negedge clk_in);
        rd_idx_in = idx[IW-1:0];
        @(negedge clk_in);
        px = rd_pos_x_out; py = rd_pos_y_out;
        vx = rd_vel_x_out; vy = rd_vel_y_out;
    endtask

    // Runs one frame; cycle 0 is the accept cycle. Issued operands are
    // popped from the scoreboard and compared as they appear.
    task automatic do_frame(input int overrun_at, input int init_at, input int init_idx,
                            input logic [7:0] init_val, input int withhold,
                            output int cycles, output int begins, output int max_gap);
        rec_t r;
        int   last_begin;
        bit   done;
        if (init_at == 0) begin
            m_px[init_idx] = init_val; m_py[init_idx] = init_val;
            m_vx[init_idx] = init_val; m_vy[init_idx] = init_val;
        end
        for (int i = 0; i < NN; i++) begin
            r.px = m_px[i]; r.py = m_py[i]; r.vx = m_vx[i]; r.vy = m_vy[i];
            sb.push_back(r);
        end
        withhold_abs = (withhold > 0) ? eng_total + withhold : -1;
        @(negedge clk_in);
        frame_start_in = 1'b1;
        if (init_at == 0) begin
            init_valid_in = 1'b1;
            init_idx_in   = init_idx[IW-1:0];
            init_pos_x_in = init_val; init_pos_y_in = init_val;
            init_vel_x_in = init_val; init_vel_y_in = init_val;
        end
        cycles = 0; begins = 0; max_gap = 0; last_begin = 0; done = 1'b0;
        for (int cyc = 1; cyc <= FRAME_BOUND && !done; cyc++) begin
            @(negedge clk_in);
            frame_start_in = (cyc == overrun_at);
            init_valid_in  = (cyc == init_at);
            if (cyc == init_at) begin
                init_idx_in   = init_idx[IW-1:0];
                init_pos_x_in = init_val; init_pos_y_in = init_val;
                init_vel_x_in = init_val; init_vel_y_in = init_val;
            end
            n_tests++;
            if (busy_out !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_in_frame: cycle %0d got %b expected 1", cyc, busy_out);
            end
            if (eng_begin_out === 1'b1) begin
                begins++;
                if (begins > 1 && (cyc - last_begin) > max_gap) max_gap = cyc - last_begin;
                last_begin = cyc;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_extra: got begin #%0d expected at most %0d", begins, NN);
                end else begin
                    r = sb.pop_front();
                    if ({eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out} !== r) begin
                        n_fail++;
                        $display("FAIL issue_values: begin #%0d got %h expected %h", begins,
                                 {eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out}, r);
                    end
                end
            end
            if (frame_done_out === 1'b1) begin
                cycles = cyc;
                done   = 1'b1;
            end
        end
        frame_start_in = 1'b0;
        init_valid_in  = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL frame_done_wait: got no pulse expected one within %0d cycles", FRAME_BOUND);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL issue_missing: got %0d left expected 0", sb.size());
        end
        sb.delete();
        if (done) begin
            exp_frames++;
            for (int i = 0; i < NN; i++) begin
                if (i != withhold - 1) begin
                    m_px[i] = m_px[i] + m_vx[i];
                    m_py[i] = m_py[i] + m_vy[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] px, py, vx, vy;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < NN; i++) begin
            m_px[i] = '0; m_py[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
        end
        exp_frames = 0;
        n_tests++;
        if ({busy_out, eng_begin_out, frame_done_out, overrun_out, timeout_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy_out, eng_begin_out, frame_done_out, overrun_out, timeout_out});
        end
        n_tests++;
        if (frame_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", frame_count_out);
        end
        n_tests++;
        if ({eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_eng: got %h expected 0",
                     {eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out});
        end
        read_node(6, px, py, vx, vy);
        n_tests++;
        if ({px, py, vx, vy} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_node6: got %h expected 0", {px, py, vx, vy});
        end
    endtask

    task automatic test_frame();
        int cycles, begins, gap;
        logic [7:0] px, py, vx, vy;
        for (int i = 0; i < NN; i++) begin
            init_node(i, 8'(i), 8'(2 * i), 8'd1, 8'hFF);
            m_px[i] = 8'(i); m_py[i] = 8'(2 * i); m_vx[i] = 8'd1; m_vy[i] = 8'hFF;
        end
        do_frame(-1, -1, 0, 8'h00, 0, cycles, begins, gap);
        n_tests++;
        if (cycles != NN * (ENG_L + 3) + 1) begin
            n_fail++;
            $display("FAIL frame_length: got %0d expected %0d", cycles, NN * (ENG_L + 3) + 1);
        end
        n_tests++;
        if (begins != NN) begin
            n_fail++;
            $display("FAIL frame_begins: got %0d expected %0d", begins, NN);
        end
        @(negedge clk_in);
        n_tests++;
        if ({busy_out, frame_done_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL frame_after_done: got %b expected 00", {busy_out, frame_done_out});
        end
        n_tests++;
        if (frame_count_out !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL frame_count: got %0d expected %0d", frame_count_out, exp_frames);
        end
        for (int i = 0; i < NN; i++) begin
            read_node(i, px, py, vx, vy);
            n_tests++;
            if ({px, py, vx, vy} !== {m_px[i], m_py[i], m_vx[i], m_vy[i]}) begin
                n_fail++;
                $display("FAIL frame_node%0d: got %h expected %h", i, {px, py, vx, vy},
                         {m_px[i], m_py[i], m_vx[i], m_vy[i]});
            end
        end
    endtask

    task automatic test_overrun();
        int cycles, begins, gap, extra_begins, extra_done;
        do_frame(10, -1, 0, 8'h00, 0, cycles, begins, gap);
        n_tests++;
        if (cycles != NN * (ENG_L + 3) + 1) begin
            n_fail++;
            $display("FAIL overrun_length: got %0d expected %0d", cycles, NN * (ENG_L + 3) + 1);
        end
        extra_begins = 0; extra_done = 0;
        repeat (80) begin
            @(negedge clk_in);
            if (eng_begin_out === 1'b1) extra_begins++;
            if (frame_done_out === 1'b1) extra_done++;
        end
        n_tests++;
        if (overrun_out !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag: got %b expected 1", overrun_out);
        end
        n_tests++;
        if ({extra_begins, extra_done} != 0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_queued: got begins=%0d done=%0d busy=%b expected 0 0 0",
                     extra_begins, extra_done, busy_out);
        end
        n_tests++;
        if (frame_count_out !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d expected %0d", frame_count_out, exp_frames);
        end
    endtask

    task automatic test_timeout();
        int cycles, begins, gap;
        logic [7:0] px, py, vx, vy;
        n_tests++;
        if (timeout_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_before: got %b expected 0", timeout_out);
        end
        do_frame(-1, -1, 0, 8'h00, 4, cycles, begins, gap);
        n_tests++;
        if (gap != TMO + 2) begin
            n_fail++;
            $display("FAIL timeout_wait: got gap %0d expected %0d", gap, TMO + 2);
        end
        n_tests++;
        if (cycles != (NN - 1) * (ENG_L + 3) + TMO + 2 + 1 || begins != NN) begin
            n_fail++;
            $display("FAIL timeout_frame: got cycles=%0d begins=%0d expected %0d %0d", cycles,
                     begins, (NN - 1) * (ENG_L + 3) + TMO + 3, NN);
        end
        @(negedge clk_in);
        n_tests++;
        if (timeout_out !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_flag: got %b expected 1", timeout_out);
        end
        for (int i = 0; i < NN; i++) begin
            read_node(i, px, py, vx, vy);
            n_tests++;
            if ({px, py, vx, vy} !== {m_px[i], m_py[i], m_vx[i], m_vy[i]}) begin
                n_fail++;
                $display("FAIL timeout_node%0d: got %h expected %h", i, {px, py, vx, vy},
                         {m_px[i], m_py[i], m_vx[i], m_vy[i]});
            end
        end
    endtask

    task automatic test_init_busy();
        int cycles, begins, gap;
        logic [7:0] px, py, vx, vy;
        do_frame(-1, 10, 5, 8'h7F, 0, cycles, begins, gap);
        read_node(5, px, py, vx, vy);
        n_tests++;
        if ({px, py, vx, vy} !== {m_px[5], m_py[5], m_vx[5], m_vy[5]}) begin
            n_fail++;
            $display("FAIL init_busy_node5: got %h expected %h", {px, py, vx, vy},
                     {m_px[5], m_py[5], m_vx[5], m_vy[5]});
        end
        init_node(5, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        m_px[5] = 8'h7F; m_py[5] = 8'h7F; m_vx[5] = 8'h7F; m_vy[5] = 8'h7F;
        read_node(5, px, py, vx, vy);
        n_tests++;
        if ({px, py, vx, vy} !== 32'h7F7F7F7F) begin
            n_fail++;
            $display("FAIL init_idle_node5: got %h expected 7f7f7f7f", {px, py, vx, vy});
        end
    endtask

    task automatic test_spurious();
        int cycles, begins, gap;
        logic [7:0] px, py, vx, vy;
        @(negedge clk_in);
        spur_req++;
        repeat (3) @(negedge clk_in);
        n_tests++;
        if (busy_out !== 1'b0 || frame_count_out !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL spur_idle_state: got busy=%b count=%0d expected 0 %0d",
                     busy_out, frame_count_out, exp_frames);
        end
        for (int i = 0; i < NN; i++) begin
            read_node(i, px, py, vx, vy);
            n_tests++;
            if ({px, py, vx, vy} !== {m_px[i], m_py[i], m_vx[i], m_vy[i]}) begin
                n_fail++;
                $display("FAIL spur_idle_node%0d: got %h expected %h", i, {px, py, vx, vy},
                         {m_px[i], m_py[i], m_vx[i], m_vy[i]});
            end
        end
        spur_issue = 1'b1;
        do_frame(-1, 0, 0, 8'h11, 0, cycles, begins, gap);
        spur_issue = 1'b0;
        n_tests++;
        if (cycles != NN * (ENG_L + 3) + 1 || begins != NN) begin
            n_fail++;
            $display("FAIL spur_issue_frame: got cycles=%0d begins=%0d expected %0d %0d",
                     cycles, begins, NN * (ENG_L + 3) + 1, NN);
        end
        for (int i = 0; i < NN; i++) begin
            read_node(i, px, py, vx, vy);
            n_tests++;
            if ({px, py, vx, vy} !== {m_px[i], m_py[i], m_vx[i], m_vy[i]}) begin
                n_fail++;
                $display("FAIL spur_issue_node%0d: got %h expected %h", i, {px, py, vx, vy},
                         {m_px[i], m_py[i], m_vx[i], m_vy[i]});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int nb, done_pulses;
        logic [7:0] px, py, vx, vy;
        nb = 0;
        @(negedge clk_in);
        frame_start_in = 1'b1;
        for (int c = 0; c < 100 && nb < 3; c++) begin
            @(negedge clk_in);
            frame_start_in = 1'b0;
            if (eng_begin_out === 1'b1) nb++;
        end
        n_tests++;
        if (nb != 3) begin
            n_fail++;
            $display("FAIL rstmid_reach_node2: got %0d begins expected 3", nb);
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < NN; i++) begin
            m_px[i] = '0; m_py[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
        end
        exp_frames = 0;
        n_tests++;
        if ({busy_out, eng_begin_out, frame_done_out, overrun_out, timeout_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL rstmid_flags: got %b expected 00000",
                     {busy_out, eng_begin_out, frame_done_out, overrun_out, timeout_out});
        end
        n_tests++;
        if ({rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out} !== 32'h0 ||
            frame_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_rd_count: got %h count=%0d expected 0 0",
                     {rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out}, frame_count_out);
        end
        done_pulses = 0;
        repeat (60) begin
            @(negedge clk_in);
            if (frame_done_out === 1'b1 || busy_out === 1'b1) done_pulses++;
        end
        n_tests++;
        if (done_pulses != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_pulses);
        end
        for (int i = 0; i < NN; i++) begin
            read_node(i, px, py, vx, vy);
            n_tests++;
            if ({px, py, vx, vy} !== 32'h0) begin
                n_fail++;
                $display("FAIL rstmid_node%0d: got %h expected 0", i, {px, py, vx, vy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_timeout();
        test_init_busy();
        test_spurious();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
